// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised multi-digit BCD up/down counter.
// DIGITS decades ripple carry/borrow internally. Supports synchronous clear,
// parallel load with per-digit BCD validation, count direction and either
// wrap or saturate at the terminal count. Pulse outputs are registered and
// last one cycle. at_max / at_min decode the present count only.
// DIGITS is intended to be in the range 1..8.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic                  ovf,
  output logic                  unf,
  output logic                  load_err,
  output logic                  at_max,
  output logic                  at_min
);

  localparam int W = 4 * DIGITS;

  // True when a 4-bit code is a legal BCD digit.
  function automatic logic digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Replace every illegal digit of a load word with zero.
  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(v[4*i +: 4])) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // True when at least one digit of a load word is illegal.
  function automatic logic any_invalid(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(v[4*i +: 4])) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  logic [W-1:0] q_r;
  logic         ovf_r;
  logic         unf_r;
  logic         load_err_r;

  logic [W-1:0] step_s;      // count value after one step in the chosen direction
  logic         carry_s;     // ripple carry/borrow; left set means terminal count
  logic [3:0]   digit_s;
  logic [W-1:0] q_nxt_s;
  logic         ovf_nxt_s;
  logic         unf_nxt_s;
  logic         load_err_nxt_s;

  // Ripple one step through the decades; carry survives only across all-9s (up) or all-0s (down).
  always_comb begin
    step_s  = q_r;
    carry_s = 1'b1;
    digit_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = q_r[4*i +: 4];
      if (carry_s) begin
        if (up) begin
          if (digit_s >= 4'd9) begin
            step_s[4*i +: 4] = 4'd0;
            carry_s          = 1'b1;
          end else begin
            step_s[4*i +: 4] = digit_s + 4'd1;
            carry_s          = 1'b0;
          end
        end else begin
          if (digit_s == 4'd0) begin
            step_s[4*i +: 4] = 4'd9;
            carry_s          = 1'b1;
          end else begin
            step_s[4*i +: 4] = digit_s - 4'd1;
            carry_s          = 1'b0;
          end
        end
      end else begin
        step_s[4*i +: 4] = digit_s;
        carry_s          = 1'b0;
      end
    end
  end

  // Next-state selection with priority clr > load > en.
  always_comb begin
    q_nxt_s        = q_r;
    ovf_nxt_s      = 1'b0;
    unf_nxt_s      = 1'b0;
    load_err_nxt_s = 1'b0;
    if (clr) begin
      q_nxt_s = {W{1'b0}};
    end else if (load) begin
      q_nxt_s        = sanitize(din);
      load_err_nxt_s = any_invalid(din);
    end else if (en) begin
      if (carry_s && !WRAP) begin
        q_nxt_s = q_r;
      end else begin
        q_nxt_s = step_s;
      end
      ovf_nxt_s = carry_s & up;
      unf_nxt_s = carry_s & ~up;
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count and pulse registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r        <= {W{1'b0}};
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_nxt_s;
      ovf_r      <= ovf_nxt_s;
      unf_r      <= unf_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  // Terminal-count decode of the present count.
  always_comb begin
    at_max = 1'b1;
    at_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q_r[4*i +: 4] != 4'd9) begin
        at_max = 1'b0;
      end else begin
        at_max = at_max;
      end
      if (q_r[4*i +: 4] != 4'd0) begin
        at_min = 1'b0;
      end else begin
        at_min = at_min;
      end
    end
  end

  assign q        = q_r;
  assign ovf      = ovf_r;
  assign unf      = unf_r;
  assign load_err = load_err_r;

endmodule
